// File: rtl/ham_pkg.sv
// Shared status type, counter width and code-width helpers for the extended-Hamming decoder.
package ham_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        CORR = 2'b01,
        DED  = 2'b10
    } err_status_t;

    localparam int unsigned CNT_W = 16;

    function automatic int unsigned ham_w(input int unsigned p);
        return (32'd1 << p) - 32'd1;
    endfunction

    function automatic int unsigned code_w(input int unsigned p);
        return ham_w(p) + 32'd1;
    endfunction

    function automatic int unsigned data_w(input int unsigned p);
        return ham_w(p) - p;
    endfunction

endpackage

// File: rtl/ham_syndrome.sv
// Combinational syndrome (S) and overall parity (G) of an extended Hamming codeword.
module ham_syndrome
    import ham_pkg::*;
#(
    parameter int unsigned P = 4
) (
    input  logic [code_w(P)-1:0] i_code,
    output logic [P-1:0]         o_syndrome,
    output logic                 o_parity
);
    localparam int unsigned CODE_W = code_w(P);

    // Positions 1..HAM_W whose index has bit_i set; bit 0 never feeds the syndrome.
    function automatic logic [CODE_W-1:0] pos_mask(input int unsigned bit_i);
        logic [CODE_W-1:0] m;
        m = '0;
        for (int unsigned k = 1; k < CODE_W; k++) begin
            if (((k >> bit_i) & 32'd1) != 32'd0) begin
                m = m | (CODE_W'(1) << k);
            end
        end
        return m;
    endfunction

    for (genvar i = 0; i < P; i++) begin : g_syn
        assign o_syndrome[i] = ^(i_code & pos_mask(i));
    end

    assign o_parity = ^i_code;

endmodule

// File: rtl/ham_secded_dec.sv
// Two-stage extended-Hamming SECDED decoder with valid/ready handshakes on both sides.
// Error counters exist only when HAM_ERR_CNT_EN is defined; otherwise they read 0.
module ham_secded_dec
    import ham_pkg::*;
#(
    parameter int unsigned P = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [code_w(P)-1:0] in_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [data_w(P)-1:0] out_data,
    output err_status_t          out_status,
    output logic [P-1:0]         out_syndrome,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     corr_cnt,
    output logic [CNT_W-1:0]     ded_cnt
);
    localparam int unsigned HAM_W  = ham_w(P);
    localparam int unsigned DATA_W = data_w(P);

    if (P < 3 || P > 6) begin : g_bad_p
        $error("ham_secded_dec: parameter P must be in 3..6");
    end

    logic [P-1:0]      w_syndrome;
    logic              w_parity;
    logic              w_advance;
    logic [DATA_W-1:0] w_data;
    err_status_t       w_status;

    logic              r_s1_valid;
    logic [HAM_W-1:0]  r_s1_ham;
    logic [P-1:0]      r_s1_syn;
    logic              r_s1_par;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_out_data;
    err_status_t       r_out_status;
    logic [P-1:0]      r_out_syn;

    ham_syndrome #(
        .P(P)
    ) u_syndrome (
        .i_code    (in_code),
        .o_syndrome(w_syndrome),
        .o_parity  (w_parity)
    );

    // Both stages move together; only a held result at the output blocks them.
    assign w_advance = ~(r_s2_valid & ~out_ready);
    assign in_ready  = w_advance;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_ham   <= '0;
            r_s1_syn   <= '0;
            r_s1_par   <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_ham <= in_code[HAM_W:1];
                r_s1_syn <= w_syndrome;
                r_s1_par <= w_parity;
            end
        end
    end

    // Bit 0 is never part of the data, so a syndrome of 0 corrects nothing visible.
    for (genvar k = 1; k <= HAM_W; k++) begin : g_pos
        if ((k & (k - 1)) != 0) begin : g_data
            assign w_data[k - 1 - $clog2(k + 1)] =
                r_s1_ham[k - 1] ^ (r_s1_par && (r_s1_syn == P'(k)));
        end
    end

    always_comb begin
        w_status = NONE;
        if (r_s1_par) begin
            w_status = CORR;
        end else if (r_s1_syn != '0) begin
            w_status = DED;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid   <= 1'b0;
            r_out_data   <= '0;
            r_out_status <= NONE;
            r_out_syn    <= '0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data   <= w_data;
                r_out_status <= w_status;
                r_out_syn    <= r_s1_syn;
            end
        end
    end

    assign out_valid    = r_s2_valid;
    assign out_data     = r_out_data;
    assign out_status   = r_out_status;
    assign out_syndrome = r_out_syn;

`ifdef HAM_ERR_CNT_EN
    logic             w_out_xfer;
    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_ded_cnt;

    assign w_out_xfer = r_s2_valid & out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_corr_cnt <= '0;
            r_ded_cnt  <= '0;
        end else if (cnt_clr) begin
            r_corr_cnt <= '0;
            r_ded_cnt  <= '0;
        end else if (w_out_xfer) begin
            if (r_out_status == CORR && r_corr_cnt != '1) begin
                r_corr_cnt <= r_corr_cnt + 1'b1;
            end
            if (r_out_status == DED && r_ded_cnt != '1) begin
                r_ded_cnt <= r_ded_cnt + 1'b1;
            end
        end
    end

    assign corr_cnt = r_corr_cnt;
    assign ded_cnt  = r_ded_cnt;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = cnt_clr;
    assign corr_cnt         = '0;
    assign ded_cnt          = '0;
`endif

endmodule

// File: tb/tb_ham_secded_dec.sv
// Bench for ham_secded_dec (P=4): directed vectors plus random traffic against a positional model.
// Counter expectations track HAM_ERR_CNT_EN when the build defines it.
module tb_ham_secded_dec;
    import ham_pkg::*;

    localparam int unsigned P      = 4;
    localparam int unsigned HAM_W  = ham_w(P);
    localparam int unsigned CODE_W = code_w(P);
    localparam int unsigned DATA_W = data_w(P);

    typedef struct {
        int unsigned data;
        int unsigned status;
        int unsigned syn;
    } exp_t;

    logic              clock     = 1'b0;
    logic              reset_n   = 1'b1;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [CODE_W-1:0] in_code   = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    err_status_t       out_status;
    logic [P-1:0]      out_syndrome;
    logic              cnt_clr   = 1'b0;
    logic [CNT_W-1:0]  corr_cnt;
    logic [CNT_W-1:0]  ded_cnt;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned n_out = 0;
    int unsigned m_corr = 0;
    int unsigned m_ded  = 0;
    exp_t        q[$];
    bit          in_taken = 1'b0;
    bit          have_prev = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data, prev_status, prev_syn;

    ham_secded_dec #(
        .P(P)
    ) u_dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_code     (in_code),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_status  (out_status),
        .out_syndrome(out_syndrome),
        .cnt_clr     (cnt_clr),
        .corr_cnt    (corr_cnt),
        .ded_cnt     (ded_cnt)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Syndrome = XOR of indices of set bits; G = parity of the popcount.
    function automatic exp_t ref_decode(input int unsigned code);
        exp_t        r;
        int unsigned s = 0;
        int unsigned g = 0;
        int unsigned fixed;
        int unsigned d = 0;
        int unsigned j = 0;
        for (int unsigned k = 0; k < CODE_W; k++) begin
            if (((code >> k) & 32'd1) != 0) begin
                g = g ^ 32'd1;
                s = s ^ k;
            end
        end
        fixed = (g != 0) ? (code ^ (32'd1 << s)) : code;
        for (int unsigned k = 1; k <= HAM_W; k++) begin
            if ((k & (k - 1)) != 0) begin
                if (((fixed >> k) & 32'd1) != 0) d = d | (32'd1 << j);
                j++;
            end
        end
        r.data   = d;
        r.syn    = s;
        r.status = (s == 0 && g == 0) ? 32'd0 : ((g != 0) ? 32'd1 : 32'd2);
        return r;
    endfunction

    function automatic int unsigned make_code(input int unsigned data, input int unsigned nerr);
        int unsigned c = 0;
        int unsigned j = 0;
        int unsigned s = 0;
        int unsigned f1;
        int unsigned f2;
        for (int unsigned k = 1; k <= HAM_W; k++) begin
            if ((k & (k - 1)) != 0) begin
                if (((data >> j) & 32'd1) != 0) c = c | (32'd1 << k);
                j++;
            end
        end
        for (int unsigned k = 1; k <= HAM_W; k++) begin
            if (((c >> k) & 32'd1) != 0) s = s ^ k;
        end
        for (int unsigned i = 0; i < P; i++) begin
            if (((s >> i) & 32'd1) != 0) c = c | (32'd1 << (32'd1 << i));
        end
        if (($countones(c) % 2) != 0) c = c | 32'd1;
        f1 = $urandom_range(CODE_W - 1, 0);
        f2 = (f1 + $urandom_range(CODE_W - 1, 1)) % CODE_W;
        if (nerr >= 1) c = c ^ (32'd1 << f1);
        if (nerr >= 2) c = c ^ (32'd1 << f2);
        return c;
    endfunction

    // Runs at the negedge: checks visible state, then models the coming edge.
    task automatic monitor();
        exp_t        e;
        int unsigned xfer_st;
        if (!reset_n) begin
            have_prev = 1'b0;
            in_taken  = 1'b0;
            return;
        end
        xfer_st = 32'd3;
        check_eq("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
        if (have_prev && prev_stall) begin
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_data", 32'(out_data), prev_data);
            check_eq("stall_status", 32'(out_status), prev_status);
            check_eq("stall_syn", 32'(out_syndrome), prev_syn);
        end else if (have_prev && !out_valid) begin
            check_eq("idle_data", 32'(out_data), prev_data);
            check_eq("idle_status", 32'(out_status), prev_status);
            check_eq("idle_syn", 32'(out_syndrome), prev_syn);
        end
        check_eq("corr_cnt", 32'(corr_cnt), m_corr);
        check_eq("ded_cnt", 32'(ded_cnt), m_ded);
        if (out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) begin
                check_eq("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                xfer_st = e.status;
                check_eq("out_data", 32'(out_data), e.data);
                check_eq("out_status", 32'(out_status), e.status);
                check_eq("out_syn", 32'(out_syndrome), e.syn);
            end
        end
`ifdef HAM_ERR_CNT_EN
        if (cnt_clr) begin
            m_corr = 0;
            m_ded  = 0;
        end else begin
            if (xfer_st == 1 && m_corr < 32'hFFFF) m_corr++;
            if (xfer_st == 2 && m_ded < 32'hFFFF) m_ded++;
        end
`endif
        in_taken = in_valid && in_ready;
        if (in_taken) q.push_back(ref_decode(32'(in_code)));
        prev_stall  = out_valid && !out_ready;
        prev_data   = 32'(out_data);
        prev_status = 32'(out_status);
        prev_syn    = 32'(out_syndrome);
        have_prev   = 1'b1;
    endtask

    task automatic step();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
    endtask

    task automatic send_directed(input logic [CODE_W-1:0] code, input int unsigned d,
                                 input int unsigned st, input int unsigned syn);
        in_valid  = 1'b1;
        in_code   = code;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("lat1_valid", 32'(out_valid), 32'd0);
        step();
        check_eq("lat2_valid", 32'(out_valid), 32'd1);
        check_eq("dir_data", 32'(out_data), d);
        check_eq("dir_status", 32'(out_status), st);
        check_eq("dir_syn", 32'(out_syndrome), syn);
        step();
    endtask

    initial begin
        int unsigned sent;
        int unsigned out_before;

        #1 reset_n = 1'b0;
        #1;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_status", 32'(out_status), 32'd0);
        check_eq("rst_syn", 32'(out_syndrome), 32'd0);
        check_eq("rst_corr", 32'(corr_cnt), 32'd0);
        check_eq("rst_ded", 32'(ded_cnt), 32'd0);
        repeat (2) step();
        reset_n = 1'b1;
        step();

        send_directed(16'h0000, 32'h000, 32'd0, 32'd0);
        send_directed(16'h0020, 32'h000, 32'd1, 32'd5);
        send_directed(16'h0001, 32'h000, 32'd1, 32'd0);
        send_directed(16'h0028, 32'h003, 32'd2, 32'd6);
        send_directed(16'h0021, 32'h002, 32'd2, 32'd5);
        send_directed(16'h0008, 32'h000, 32'd1, 32'd3);

        // Eight-word stream with the output blocked on cycles 3..5.
        sent       = 0;
        out_before = n_out;
        for (int c = 0; c < 40 && (sent < 8 || q.size() != 0); c++) begin
            in_valid  = (sent < 8);
            in_code   = CODE_W'(make_code((sent * 97 + 3) % 2048, sent % 2));
            out_ready = !(c >= 3 && c <= 5);
            step();
            if (in_taken) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("stream_count", n_out - out_before, 32'd8);

        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(9, 0) < 7);
            in_code   = CODE_W'(make_code($urandom_range(2047, 0), $urandom_range(2, 0)));
            out_ready = ($urandom_range(9, 0) < 7);
            cnt_clr   = ($urandom_range(39, 0) == 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        repeat (4) step();
        check_eq("drain_left", q.size(), 32'd0);
        check_eq("drain_valid", 32'(out_valid), 32'd0);

        // Reset with two words in flight.
        in_valid = 1'b1;
        in_code  = CODE_W'(make_code(11, 0));
        step();
        in_code = CODE_W'(make_code(22, 1));
        step();
        in_valid = 1'b0;
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_data", 32'(out_data), 32'd0);
        check_eq("mid_rst_status", 32'(out_status), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        m_corr = 0;
        m_ded  = 0;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (4) begin
            step();
            check_eq("post_rst_stale", 32'(out_valid), 32'd0);
        end
        send_directed(16'h0020, 32'h000, 32'd1, 32'd5);

`ifdef HAM_ERR_CNT_EN
        cnt_clr = 1'b1;
        step();
        cnt_clr   = 1'b0;
        in_valid  = 1'b1;
        in_code   = 16'h0001;
        out_ready = 1'b1;
        repeat (65537) step();
        in_valid = 1'b0;
        repeat (3) step();
        check_eq("corr_sat", 32'(corr_cnt), 32'hFFFF);
        in_valid = 1'b1;
        repeat (3) step();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check_eq("corr_clr", 32'(corr_cnt), 32'd0);
        in_valid = 1'b0;
        repeat (3) step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
